// File: rtl/lsu_axi_master_pkg.sv
// Shared definitions for the AXI4-Lite load/store unit: op codes, error codes,
// AXI response codes, FSM states and op decode helpers.
package lsu_axi_master_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LD  = 4'h3,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_LWU = 4'h6,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA,
    OP_SD  = 4'hB
  } lsu_op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_RESP
  } lsu_state_e;

  // Doubleword and LWU ops only exist on a 64-bit datapath.
  function automatic logic op_illegal(input logic [3:0] op, input int unsigned data_w);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b0;
      OP_LD, OP_LWU, OP_SD: return data_w != 64;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [2:0] ea_lo);
    case (op[1:0])
      2'd1:    return ea_lo[0];
      2'd2:    return |ea_lo[1:0];
      2'd3:    return |ea_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axi_master_lane.sv
// Byte-lane steering: store data shift and strobe generation, plus load
// extraction with sign/zero extension.
module lsu_lane #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [DATA_W-1:0] ldata_o
);

  logic [DATA_W-1:0] dmask;
  logic [STRB_W-1:0] smask;
  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    dmask = '1;
    smask = '1;
    case (size_i)
      2'd0: begin dmask = DATA_W'(8'hFF);         smask = STRB_W'(1'b1);  end
      2'd1: begin dmask = DATA_W'(16'hFFFF);      smask = STRB_W'(2'b11); end
      2'd2: begin dmask = DATA_W'(32'hFFFF_FFFF); smask = STRB_W'(4'hF);  end
      default: ;
    endcase

    wdata_o = (wdata_i & dmask) << {off_i, 3'b000};
    wstrb_o = smask << off_i;

    shifted = rdata_i >> {off_i, 3'b000};
    sign    = 1'b0;
    case (size_i)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = 1'b0;
    endcase
    ldata_o = shifted & dmask;
    if (!unsigned_i && sign) ldata_o = ldata_o | ~dmask;
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit acting as an AXI4-Lite master: one request at a time,
// alignment/op checks, AR/R or AW/W/B transaction, result back to the WBU.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        lsu_op_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [1:0]        resp_err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  localparam int unsigned OFF_W = $clog2(STRB_W);

  lsu_state_e        state_q;
  logic [2:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic              resp_valid_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [DATA_W-1:0] resp_data_q, wdata_q;
  logic [1:0]        resp_err_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [STRB_W-1:0] wstrb_q;

  logic [ADDR_W-1:0] ea, bus_addr;
  logic [2:0]        lane_op;
  logic [OFF_W-1:0]  lane_off;
  logic [DATA_W-1:0] lane_wdata, lane_ldata;
  logic [STRB_W-1:0] lane_wstrb;
  logic              aw_done, w_done;

  // The single lane instance serves the store path from the live request in
  // IDLE and the load path from the latched op/offset afterwards.
  always_comb begin
    ea       = ADDR_W'(base_i + imm_i);
    bus_addr = {ea[ADDR_W-1:OFF_W], OFF_W'(0)};
    lane_op  = (state_q == ST_IDLE) ? lsu_op_i[2:0] : op_q;
    lane_off = (state_q == ST_IDLE) ? ea[OFF_W-1:0] : off_q;
    aw_done  = !awvalid_q || awready_i;
    w_done   = !wvalid_q || wready_i;
  end

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .size_i     (lane_op[1:0]),
    .unsigned_i (lane_op[2]),
    .off_i      (lane_off),
    .wdata_i    (wdata_i),
    .rdata_i    (rdata_i),
    .wdata_o    (lane_wdata),
    .wstrb_o    (lane_wstrb),
    .ldata_o    (lane_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid_i) begin
          op_q  <= lsu_op_i[2:0];
          off_q <= ea[OFF_W-1:0];
          if (op_illegal(lsu_op_i, DATA_W)) begin
            resp_err_q   <= ERR_ILLEGAL;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (op_misaligned(lsu_op_i, ea[2:0])) begin
            resp_err_q   <= ERR_MISALIGN;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (lsu_op_i[3]) begin
            awaddr_q  <= bus_addr;
            wdata_q   <= lane_wdata;
            wstrb_q   <= lane_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WR;
          end else begin
            araddr_q  <= bus_addr;
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: if (arready_i) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= ST_R;
        end
        ST_R: if (rvalid_i) begin
          rready_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= (rresp_i != AXI_OKAY) ? ERR_BUS : ERR_OK;
          resp_data_q  <= (rresp_i != AXI_OKAY) ? '0 : lane_ldata;
          state_q      <= ST_RESP;
        end
        ST_WR: begin
          if (awvalid_q && awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end
        ST_B: if (bvalid_i) begin
          bready_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= (bresp_i != AXI_OKAY) ? ERR_BUS : ERR_OK;
          resp_data_q  <= '0;
          state_q      <= ST_RESP;
        end
        ST_RESP: if (resp_ready_i) begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE) && rst;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign awaddr_o     = awaddr_q;
  assign awvalid_o    = awvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wvalid_o     = wvalid_q;
  assign bready_o     = bready_q;

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Parametrised load/store unit that replaces the fixed-width, internally-memory-backed LSU with an AXI4-Lite master that talks to external data memory.
- Accepts one memory request at a time from the EXU over a valid/ready handshake and computes the effective address.
- Checks alignment, generates byte lanes/strobes, runs the AR/R or AW/W/B transaction, and extracts/sign-extends load data.
- Returns result plus error code to the WBU over a second valid/ready handshake.
- Supports 32- or 64-bit datapaths, decoupled AW/W handshakes, bus-error reporting and misalignment traps with no bus access.

Parameters:
ADDR_W, 32, AXI address width; effective address truncated to this width.
DATA_W, 32, datapath and AXI data width; legal values 32 or 64.
STRB_W, DATA_W/8, write strobe width (derived, not overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid_i  in  1  EXU request valid
req_ready_o  out  1  LSU can accept a request
lsu_op_i  in  4  operation code (shared constants)
base_i  in  DATA_W  rs1 value
imm_i  in  DATA_W  sign-extended immediate
wdata_i  in  DATA_W  rs2 store data
resp_valid_o  out  1  result valid to WBU
resp_ready_i  in  1  WBU accepts result
resp_data_o  out  DATA_W  load result (0 for stores/errors)
resp_err_o  out  2  00 ok, 01 misaligned, 10 bus error, 11 illegal op
araddr_o  out  ADDR_W  read address
arvalid_o  out  1  read address valid
arready_i  in  1  read address ready
rdata_i  in  DATA_W  read data
rresp_i  in  2  read response
rvalid_i  in  1  read data valid
rready_o  out  1  read data ready
awaddr_o  out  ADDR_W  write address
awvalid_o  out  1  write address valid
awready_i  in  1  write address ready
wdata_o  out  DATA_W  write data (lane-shifted)
wstrb_o  out  STRB_W  write byte strobes
wvalid_o  out  1  write data valid
wready_i  in  1  write data ready
bresp_i  in  2  write response
bvalid_i  in  1  write response valid
bready_o  out  1  write response ready

Behaviour:
- Reset: rst low asynchronously forces state IDLE and clears all valid/ready outputs, resp_data_o, resp_err_o, addresses, wdata_o and wstrb_o to 0.
- Reset mid-transaction abandons the transaction with no response; arvalid/awvalid/wvalid drop immediately.
- req_ready_o = (state==IDLE) && rst high. Accept on req_valid_i & req_ready_o: latch op, ea = base_i + imm_i (ADDR_W LSBs), offset = ea mod STRB_W, and wdata_i.
- Bus address is ea with the low log2(STRB_W) bits zeroed.
- Misaligned (err 01): H with ea[0]!=0, W with ea[1:0]!=0, D with ea[2:0]!=0. Byte accesses are never misaligned.
- Illegal (err 11): LD, SD or LWU when DATA_W=32, or any undefined code.
- On error: no bus activity; go to RESP with resp_data 0.
- Store lanes: wdata_o = size-masked wdata_i << (offset*8); wstrb_o = size mask (1/3/F/FF) << offset.
- Load extract: (rdata_i >> offset*8) masked to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD) to DATA_W.
- FSM:
  - IDLE -> AR (load), WR (store) or RESP (error).
  - AR: arvalid=1 until arready_i, then R.
  - R: rready=1; on rvalid_i capture data and rresp, then RESP.
  - WR: awvalid and wvalid asserted together; each drops independently after its own handshake; leave when both are done (same-cycle completion allowed), then B.
  - B: bready=1; on bvalid_i go to RESP.
  - RESP: resp_valid=1, held with stable payload until resp_ready_i, then IDLE. IDLE is not entered in the same cycle as a new accept.
- rresp/bresp != 00 gives err 10 and resp_data 0.
- AXI rules: a valid, once asserted, stays high with a stable payload until handshake. Ready outputs never depend combinationally on the slave's valid.
- Minimum latency with zero-wait slave: accept in cycle T, arvalid at T+1, rvalid at T+2, resp_valid at T+3. Store: AW/W at T+1, B at T+2, resp_valid at T+3. Error: resp_valid at T+1.
- Only one outstanding transaction; no pipelining across requests.

Decomposition:
- Shared defines: LSU op encodings (LB 0, LH 1, LW 2, LD 3, LBU 4, LHU 5, LWU 6, SB 8, SH 9, SW A, SD B; bit3 = store), error codes, AXI resp codes (OKAY 00, SLVERR 10), FSM state encoding.
- One combinational sub-module lsu_lane: store shift/strobe generation plus load extract/extend, parametrised by DATA_W.

Test Plan:
1. DATA_W=32, LW base 0x80000000 imm 4, zero-wait slave, rdata 0xDEADBEEF -> araddr 0x80000004, resp_data 0xDEADBEEF, err 00, resp_valid 3 cycles after accept.
2. LB ea 0x80000003, rdata 0x80FF1234 -> araddr 0x80000000, resp_data 0xFFFFFF80; repeat as LBU -> 0x00000080.
3. SH ea 0x80000002, wdata_i 0x1234ABCD, awready 3 cycles before wready -> awaddr 0x80000000, wdata_o 0xABCD0000, wstrb_o 0b1100; awvalid drops after its handshake while wvalid is held; bresp 00 -> err 00.
4. LW ea 0x80000001 -> no arvalid ever; resp_err 01 at T+1. LD with DATA_W=32 -> err 11. DATA_W=64 LD ea 0x8 -> normal 64-bit read.
5. LH with rresp 10, rdata 0xFFFF -> resp_err 10, resp_data 0; SW with bresp 10 -> err 10.
6. resp_ready low for 5 cycles -> resp_valid, data and err held, req_ready 0; rst pulsed low during AR wait -> arvalid 0 immediately, no response, req_ready 1 after release.
